// File: rtl/smoke_clkgen_if.sv
// Configuration write bus for smoke_clkgen: valid/ready handshake carrying
// a channel index, a divisor and an enable.
interface smoke_clkgen_if #(
   parameter int unsigned N_CHAN = 4,
   parameter int unsigned DIV_W  = 8
);
   localparam int unsigned CH_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_chan;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_en;

   // Bench / configuring agent side
   modport master (
      output cfg_valid,
      output cfg_chan,
      output cfg_div,
      output cfg_en,
      input  cfg_ready
   );

   // Clock generator side
   modport slave (
      input  cfg_valid,
      input  cfg_chan,
      input  cfg_div,
      input  cfg_en,
      output cfg_ready
   );
endinterface

// File: rtl/smoke_clkgen.sv
// smoke_clkgen: N programmable divided clocks and strobes derived from one
// master clock, plus a reset sequencer that holds rst_out for RST_HOLD
// cycles after reset release and then raises locked.
module smoke_clkgen #(
   parameter int unsigned N_CHAN   = 4,
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DEF_DIV  = 1,
   parameter int unsigned DEF_EN   = 1,
   parameter int unsigned RST_HOLD = 8
) (
   input  logic              clock,
   input  logic              reset,
   smoke_clkgen_if.slave     cfg,
   output logic [N_CHAN-1:0] chan_clk,
   output logic [N_CHAN-1:0] chan_stb,
   output logic              rst_out,
   output logic              locked
);

   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEF_DIV);
   localparam logic              EN_RST    = (DEF_EN != 0);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

   logic [HOLD_W-1:0] hold_cnt;

   logic [DIV_W-1:0]  div_q [N_CHAN];
   logic [DIV_W-1:0]  cnt_q [N_CHAN];
   logic [N_CHAN-1:0] en_q;

   logic              wr_acc;
   logic [N_CHAN-1:0] wr_hit;
   logic [N_CHAN-1:0] active;
   logic [N_CHAN-1:0] term;

   // Writes are only accepted once the sequencer has locked.
   assign cfg.cfg_ready = locked;
   assign wr_acc        = cfg.cfg_valid && locked;

   // Hold rst_out for RST_HOLD edges after release, then lock until next reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         rst_out  <= 1'b1;
         locked   <= 1'b0;
      end else if (!locked) begin
         if (hold_cnt == HOLD_LAST) begin
            rst_out <= 1'b0;
            locked  <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Decode the write target; indices at or beyond N_CHAN match nothing and
   // are therefore accepted but ignored.
   always_comb begin
      wr_hit = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         wr_hit[i] = wr_acc && (32'(cfg.cfg_chan) == i);
      end
   end

   // Per-channel activity and terminal-count detection.
   always_comb begin
      active = '0;
      term   = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         active[i] = locked && en_q[i] && (div_q[i] != '0);
         term[i]   = (cnt_q[i] == (div_q[i] - DIV_ONE));
      end
   end

   // Channel configuration registers, updated by accepted writes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q <= {N_CHAN{EN_RST}};
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            div_q[i] <= DIV_RST;
         end
      end else begin
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (wr_hit[i]) begin
               div_q[i] <= cfg.cfg_div;
               en_q[i]  <= cfg.cfg_en;
            end
         end
      end
   end

   // Divider counters and outputs; a write on the terminal edge takes
   // priority, so that edge produces neither a strobe nor a toggle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chan_clk <= '0;
         chan_stb <= '0;
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (wr_hit[i] || !active[i]) begin
               cnt_q[i]    <= '0;
               chan_clk[i] <= 1'b0;
               chan_stb[i] <= 1'b0;
            end else if (term[i]) begin
               cnt_q[i]    <= '0;
               chan_clk[i] <= ~chan_clk[i];
               chan_stb[i] <= 1'b1;
            end else begin
               cnt_q[i]    <= cnt_q[i] + DIV_ONE;
               chan_stb[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_smoke_clkgen.sv
// Self-checking bench for smoke_clkgen: directed scenarios followed by
// random configuration traffic, compared against an arithmetic model that
// tracks edges-since-activation per channel.
module tb_smoke_clkgen;

   localparam int unsigned NC   = 6;
   localparam int unsigned DW   = 8;
   localparam int unsigned DDIV = 1;
   localparam int unsigned DEN  = 1;
   localparam int unsigned RH   = 8;
   localparam int unsigned CW   = (NC > 1) ? $clog2(NC) : 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [NC-1:0] chan_clk;
   logic [NC-1:0] chan_stb;
   logic          rst_out;
   logic          locked;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_edges;
   bit m_locked;
   int m_div [NC];
   bit m_en  [NC];
   int m_k   [NC];   // active edges since (re)start of the channel

   always #5 clock = ~clock;

   smoke_clkgen_if #(.N_CHAN(NC), .DIV_W(DW)) cfg_if ();

   smoke_clkgen #(
      .N_CHAN   (NC),
      .DIV_W    (DW),
      .DEF_DIV  (DDIV),
      .DEF_EN   (DEN),
      .RST_HOLD (RH)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .cfg      (cfg_if),
      .chan_clk (chan_clk),
      .chan_stb (chan_stb),
      .rst_out  (rst_out),
      .locked   (locked)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_edges  = 0;
      m_locked = 1'b0;
      for (int i = 0; i < NC; i++) begin
         m_div[i] = DDIV;
         m_en[i]  = (DEN != 0);
         m_k[i]   = 0;
      end
   endtask

   function automatic bit exp_stb(input int i);
      return (m_k[i] > 0) && (m_k[i] % m_div[i] == 0);
   endfunction

   function automatic bit exp_clk(input int i);
      if (m_k[i] == 0) return 1'b0;
      return ((m_k[i] / m_div[i]) % 2) == 1;
   endfunction

   // Advance the model by one rising edge using the inputs seen on that edge.
   task automatic model_edge();
      bit lb;
      bit acc;
      lb  = m_locked;
      acc = cfg_if.cfg_valid && m_locked;
      for (int i = 0; i < NC; i++) begin
         if (acc && (int'(cfg_if.cfg_chan) == i)) begin
            m_div[i] = int'(cfg_if.cfg_div);
            m_en[i]  = cfg_if.cfg_en;
            m_k[i]   = 0;
         end else if (lb && m_en[i] && m_div[i] != 0) begin
            m_k[i]++;
         end else begin
            m_k[i] = 0;
         end
      end
      if (!m_locked) begin
         m_edges++;
         if (m_edges == RH) m_locked = 1'b1;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [NC-1:0] e_clk;
      logic [NC-1:0] e_stb;
      for (int i = 0; i < NC; i++) begin
         e_clk[i] = exp_clk(i);
         e_stb[i] = exp_stb(i);
      end
      check({tag, ".rst_out"},   32'(rst_out),          32'(!m_locked));
      check({tag, ".locked"},    32'(locked),           32'(m_locked));
      check({tag, ".cfg_ready"}, 32'(cfg_if.cfg_ready), 32'(m_locked));
      check({tag, ".chan_clk"},  32'(chan_clk),         32'(e_clk));
      check({tag, ".chan_stb"},  32'(chan_stb),         32'(e_stb));
   endtask

   // Called at a falling edge: drive inputs, take one rising edge, compare.
   task automatic step(input string tag, input logic v, input logic [CW-1:0] ch,
                       input logic [DW-1:0] d, input logic e);
      cfg_if.cfg_valid = v;
      cfg_if.cfg_chan  = ch;
      cfg_if.cfg_div   = d;
      cfg_if.cfg_en    = e;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      compare_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int j = 0; j < n; j++) step(tag, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      int  budget;
      bit  found;
      int  stb1_cnt;

      reset            = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_chan  = '0;
      cfg_if.cfg_div   = '0;
      cfg_if.cfg_en    = 1'b0;
      model_reset();

      // Reset state while reset is held
      @(negedge clock);
      @(negedge clock);
      compare_all("reset");

      // Release and lock sequence
      reset = 1'b0;
      idle("hold", RH - 1);
      check("hold.locked_before_last", 32'(locked), 32'd0);
      idle("lock", 1);
      check("lock.locked_at_hold", 32'(locked), 32'd1);

      // Default run: every channel at div=1
      idle("default", 6);

      // Program ch2 div=5; other channels undisturbed
      step("ch2_wr", 1'b1, CW'(2), DW'(5), 1'b1);
      idle("ch2_run", 25);

      // Mid-count rewrite on the terminal edge of ch1
      step("ch1_wr10", 1'b1, CW'(1), DW'(10), 1'b1);
      found = 1'b0;
      for (budget = 0; budget < 30 && !found; budget++) begin
         if (m_k[1] % 10 == 9) found = 1'b1;
         else idle("ch1_wait", 1);
      end
      check("ch1_terminal_reached", 32'(found), 32'd1);
      step("ch1_wr3", 1'b1, CW'(1), DW'(3), 1'b1);
      check("ch1_no_stb_on_rewrite", 32'(chan_stb[1]), 32'd0);
      stb1_cnt = 0;
      for (int j = 0; j < 3; j++) begin
         idle("ch1_run", 1);
         if (chan_stb[1]) stb1_cnt++;
      end
      check("ch1_one_stb_in_3", 32'(stb1_cnt), 32'd1);
      check("ch1_stb_at_3", 32'(chan_stb[1]), 32'd1);

      // Disable ch0 while its clock is high
      found = 1'b0;
      for (budget = 0; budget < 10 && !found; budget++) begin
         if (exp_clk(0)) found = 1'b1;
         else idle("ch0_wait", 1);
      end
      check("ch0_clk_high_reached", 32'(found), 32'd1);
      step("ch0_dis", 1'b1, CW'(0), DW'(7), 1'b0);
      check("ch0_dis.clk", 32'(chan_clk[0]), 32'd0);
      idle("ch0_off", 5);
      step("ch0_div0", 1'b1, CW'(0), DW'(0), 1'b1);
      check("ch0_div0.stb", 32'(chan_stb[0]), 32'd0);
      idle("ch0_div0_run", 5);
      step("ch0_re", 1'b1, CW'(0), DW'(1), 1'b1);
      step("oob6", 1'b1, CW'(6), DW'(4), 1'b1);
      step("oob7", 1'b1, CW'(7), DW'(0), 1'b0);
      idle("oob_run", 5);

      // Async reset mid-run with ch3 at div=7
      step("ch3_wr7", 1'b1, CW'(3), DW'(7), 1'b1);
      idle("ch3_run", 10);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      @(negedge clock);
      compare_all("async_rst_hold");
      reset = 1'b0;
      idle("relock", RH + 6);
      check("ch3_default_div.stb", 32'(chan_stb[3]), 32'd1);

      // Random configuration traffic
      for (int j = 0; j < 400; j++) begin
         if ($urandom_range(0, 3) == 0)
            step("rnd", 1'b1, CW'($urandom_range(0, 7)), DW'($urandom_range(0, 6)),
                 ($urandom_range(0, 4) != 0));
         else
            idle("rnd", 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
